// File: rtl/game_pkg.sv
// Shared state/winner encodings and default game parameters for game_state_ctl.
package game_pkg;

    typedef enum logic [2:0] {
        ST_MENU       = 3'd0,
        ST_WAIT_SERVE = 3'd1,
        ST_PLAY       = 3'd2,
        ST_PAUSE      = 3'd3,
        ST_GAME_OVER  = 3'd4
    } game_state_t;

    typedef enum logic [1:0] {
        WIN_NONE = 2'b00,
        WIN_P1   = 2'b01,
        WIN_P2   = 2'b10
    } winner_t;

    localparam logic [3:0] DEF_WIN_POINTS   = 4'd11;
    localparam logic [7:0] DEF_PAUSE_FRAMES = 8'd60;

    // Player 1 takes precedence when both reach the target in the same frame.
    function automatic winner_t pick_winner(input logic [3:0] p1,
                                            input logic [3:0] p2,
                                            input logic [3:0] win_pts);
        winner_t w;
        w = WIN_NONE;
        if (p1 >= win_pts)      w = WIN_P1;
        else if (p2 >= win_pts) w = WIN_P2;
        return w;
    endfunction

endpackage

// File: rtl/btn_edge.sv
// Rising-edge detector for an already-synchronised level button.
module btn_edge (
    input  logic clk65MHz,
    input  logic rst,
    input  logic btn,
    output logic rise
);

    logic prev;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk65MHz) begin
        if (!rst) prev <= 1'b0;
        else      prev <= btn;
    end

    assign rise = btn & ~prev;

endmodule

// File: rtl/game_state_ctl.sv
// Game flow controller: menu, serve, play, post-point pause and game over.
// Optional macro GAME_AUTO_SERVE_EN: serve is issued automatically in WAIT_SERVE.
module game_state_ctl
    import game_pkg::*;
#(
    parameter logic [3:0] WIN_POINTS   = DEF_WIN_POINTS,
    parameter logic [7:0] PAUSE_FRAMES = DEF_PAUSE_FRAMES
) (
    input  logic       clk65MHz,
    input  logic       rst,
    input  logic       end_of_frame,
    input  logic       btn_start,
    input  logic       btn_mode,
    input  logic       btn_serve,
    input  logic [3:0] points_player_1,
    input  logic [3:0] points_player_2,
    output logic       screen_idle,
    output logic       screen_multi,
    output logic       serve,
    output logic [1:0] winner,
    output logic [2:0] state_dbg
);

    game_state_t state;
    winner_t     win_q;
    winner_t     score_win;
    logic [7:0]  frame_cnt;
    logic [3:0]  last_p1;
    logic [3:0]  last_p2;
    logic        serve_armed;
    logic        serve_ready;
    logic        score_changed;
    logic        start_rise;
    logic        mode_rise;
    logic        serve_rise;

    btn_edge u_start_edge (.clk65MHz(clk65MHz), .rst(rst), .btn(btn_start), .rise(start_rise));
    btn_edge u_mode_edge  (.clk65MHz(clk65MHz), .rst(rst), .btn(btn_mode),  .rise(mode_rise));
    btn_edge u_serve_edge (.clk65MHz(clk65MHz), .rst(rst), .btn(btn_serve), .rise(serve_rise));

    assign score_win     = pick_winner(points_player_1, points_player_2, WIN_POINTS);
    assign score_changed = (points_player_1 != last_p1) || (points_player_2 != last_p2);

`ifdef GAME_AUTO_SERVE_EN
    assign serve_ready = 1'b1;
`else
    assign serve_ready = serve_armed;
`endif

    always_ff @(posedge clk65MHz) begin
        if (!rst) begin
            state        <= ST_MENU;
            screen_idle  <= 1'b1;
            screen_multi <= 1'b0;
            serve        <= 1'b0;
            win_q        <= WIN_NONE;
            frame_cnt    <= 8'd0;
            last_p1      <= 4'd0;
            last_p2      <= 4'd0;
            serve_armed  <= 1'b0;
        end else begin
            // Score snapshot refreshes every frame so a point is seen exactly once.
            if (end_of_frame) begin
                last_p1 <= points_player_1;
                last_p2 <= points_player_2;
            end

            case (state)
                ST_MENU: begin
                    if (mode_rise) screen_multi <= ~screen_multi;
                    if (start_rise) begin
                        state       <= ST_WAIT_SERVE;
                        screen_idle <= 1'b0;
                    end
                end

                ST_WAIT_SERVE: begin
                    if (serve) begin
                        if (end_of_frame) begin
                            serve <= 1'b0;
                            state <= ST_PLAY;
                        end
                    end else if (serve_ready && end_of_frame) begin
                        serve       <= 1'b1;
                        serve_armed <= 1'b0;
                    end else if (serve_rise) begin
                        serve_armed <= 1'b1;
                    end
                end

                ST_PLAY: begin
                    if (score_changed) begin
                        if (score_win != WIN_NONE) begin
                            state       <= ST_GAME_OVER;
                            win_q       <= score_win;
                            screen_idle <= 1'b1;
                        end else begin
                            state     <= ST_PAUSE;
                            frame_cnt <= PAUSE_FRAMES;
                        end
                    end
                end

                ST_PAUSE: begin
                    // Exit on the frame that would take the counter to zero; never wraps.
                    if (end_of_frame) begin
                        if (frame_cnt <= 8'd1) begin
                            frame_cnt <= 8'd0;
                            state     <= ST_WAIT_SERVE;
                        end else begin
                            frame_cnt <= frame_cnt - 8'd1;
                        end
                    end
                end

                ST_GAME_OVER: begin
                    if (start_rise) begin
                        state <= ST_MENU;
                        win_q <= WIN_NONE;
                    end
                end

                default: begin
                    state       <= ST_MENU;
                    screen_idle <= 1'b1;
                    serve       <= 1'b0;
                end
            endcase
        end
    end

    assign winner    = win_q;
    assign state_dbg = state;

endmodule

// File: tb/tb_game_state_ctl.sv
// Self-checking bench for game_state_ctl: randomized frame timing, button holds and scores.
module tb_game_state_ctl;
    import game_pkg::*;

    localparam int WIN       = 11;
    localparam int PAUSE_LEN = 60;
    localparam int B_START   = 0;
    localparam int B_MODE    = 1;
    localparam int B_SERVE   = 2;

    logic       clk65MHz = 1'b0;
    logic       rst = 1'b0;
    logic       end_of_frame = 1'b0;
    logic       btn_start = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_serve = 1'b0;
    logic [3:0] points_player_1 = 4'd0;
    logic [3:0] points_player_2 = 4'd0;
    logic       screen_idle;
    logic       screen_multi;
    logic       serve;
    logic [1:0] winner;
    logic [2:0] state_dbg;

    int checks = 0;
    int errors = 0;

    // Reference model: selected mode and the two scores fed to the DUT.
    bit exp_multi = 1'b0;
    int s1 = 0;
    int s2 = 0;

    game_state_ctl dut (
        .clk65MHz        (clk65MHz),
        .rst             (rst),
        .end_of_frame    (end_of_frame),
        .btn_start       (btn_start),
        .btn_mode        (btn_mode),
        .btn_serve       (btn_serve),
        .points_player_1 (points_player_1),
        .points_player_2 (points_player_2),
        .screen_idle     (screen_idle),
        .screen_multi    (screen_multi),
        .serve           (serve),
        .winner          (winner),
        .state_dbg       (state_dbg)
    );

    always #5 clk65MHz = ~clk65MHz;

    // Frame pulses: one cycle high, at least two cycles low in between.
    initial begin : frame_gen
        forever begin
            repeat ($urandom_range(2, 6)) @(posedge clk65MHz);
            #1 end_of_frame = 1'b1;
            @(posedge clk65MHz);
            #1 end_of_frame = 1'b0;
        end
    end

    initial begin : watchdog
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int model_winner(input int a, input int b);
        if (a >= WIN) return 1;
        if (b >= WIN) return 2;
        return 0;
    endfunction

    task automatic drive_btn(input int which, input logic val);
        case (which)
            B_START: btn_start = val;
            B_MODE:  btn_mode  = val;
            default: btn_serve = val;
        endcase
    endtask

    task automatic press(input int which, input int hold);
        drive_btn(which, 1'b1);
        repeat (hold) @(posedge clk65MHz);
        #1 drive_btn(which, 1'b0);
        repeat (2) @(posedge clk65MHz);
        #1;
    endtask

    // Returns just after the posedge that follows an end_of_frame pulse.
    task automatic sync_eof();
        int n;
        n = 0;
        do begin
            @(negedge clk65MHz);
            n++;
        end while (!end_of_frame && n < 100);
        @(posedge clk65MHz);
        #1;
    endtask

    task automatic wait_state(input string tag, input logic [2:0] target, input int budget);
        int n;
        n = 0;
        while (state_dbg !== target && n < budget) begin
            @(negedge clk65MHz);
            n++;
        end
        check(tag, state_dbg, target);
    endtask

    task automatic serve_point();
        sync_eof();
        press(B_SERVE, $urandom_range(1, 4));
        wait_state("serve_to_play", ST_PLAY, 100);
        check("play_idle", screen_idle, 0);
    endtask

    // Present a new score pair during PLAY and follow the expected outcome.
    task automatic score_point(input int a, input int b);
        int w, cnt, n;
        bit serve_seen;
        sync_eof();
        s1 = a;
        s2 = b;
        points_player_1 = 4'(a);
        points_player_2 = 4'(b);
        w = model_winner(s1, s2);
        if (w == 0) begin
            wait_state("enter_pause", ST_PAUSE, 5);
            cnt = 0;
            n = 0;
            serve_seen = 1'b0;
            while (state_dbg == ST_PAUSE && n < 1000) begin
                if (end_of_frame) cnt++;
                if (serve) serve_seen = 1'b1;
                @(negedge clk65MHz);
                n++;
            end
            check("pause_exit_state", state_dbg, ST_WAIT_SERVE);
            check("pause_frames", cnt, PAUSE_LEN);
            check("pause_no_serve", serve_seen, 0);
            serve_point();
        end else begin
            wait_state("enter_game_over", ST_GAME_OVER, 5);
            check("winner", winner, w);
            check("game_over_idle", screen_idle, 1);
        end
    endtask

    task automatic end_game();
        press(B_MODE, $urandom_range(1, 5));
        check("mode_ignored_game_over", screen_multi, exp_multi);
        check("still_game_over", state_dbg, ST_GAME_OVER);
        press(B_START, 40);
        check("held_start_to_menu", state_dbg, ST_MENU);
        check("winner_cleared", winner, 0);
        check("menu_idle", screen_idle, 1);
        s1 = 0;
        s2 = 0;
        points_player_1 = 4'd0;
        points_player_2 = 4'd0;
    endtask

    initial begin : main
        int n_mode, frames, rises, rise_at, serve_frames, guard, a;
        bit prev_serve;

        // Reset values while rst is held low.
        repeat (3) @(posedge clk65MHz);
        @(negedge clk65MHz);
        check("rst_state", state_dbg, ST_MENU);
        check("rst_idle", screen_idle, 1);
        check("rst_multi", screen_multi, 0);
        check("rst_serve", serve, 0);
        check("rst_winner", winner, 0);
        @(posedge clk65MHz);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk65MHz);
        #1;

        // Mode toggles in MENU, then start.
        n_mode = $urandom_range(1, 3);
        for (int i = 0; i < n_mode; i++) begin
            press(B_MODE, $urandom_range(1, 8));
            exp_multi = ~exp_multi;
        end
        check("menu_mode_toggle", screen_multi, exp_multi);
        check("menu_stays", state_dbg, ST_MENU);
        press(B_START, $urandom_range(1, 30));
        check("start_multi", screen_multi, exp_multi);
        check("start_idle", screen_idle, 0);
        check("start_state", state_dbg, ST_WAIT_SERVE);

        // Serve button held across 100 frames: one pulse, one frame long.
        sync_eof();
        btn_serve = 1'b1;
        frames = 0; rises = 0; rise_at = -1; serve_frames = 0; guard = 0; prev_serve = 1'b0;
        while (frames < 100 && guard < 2000) begin
            @(negedge clk65MHz);
            guard++;
            if (serve && !prev_serve) begin
                rises++;
                rise_at = frames;
            end
            if (serve && end_of_frame) serve_frames++;
            if (end_of_frame) frames++;
            prev_serve = serve;
        end
        btn_serve = 1'b0;
        check("serve_hold_frames", frames, 100);
        check("serve_pulse_count", rises, 1);
        check("serve_rise_frame", rise_at, 1);
        check("serve_pulse_len", serve_frames, 1);
        check("serve_then_play", state_dbg, ST_PLAY);

        // Mode button during play must not change the mode.
        @(posedge clk65MHz);
        #1;
        press(B_MODE, $urandom_range(1, 5));
        check("mode_ignored_play", screen_multi, exp_multi);
        check("play_after_mode", state_dbg, ST_PLAY);

        // Game 1: random single-point increments until someone wins.
        while (model_winner(s1, s2) == 0) begin
            if ($urandom_range(0, 1) == 1) score_point(s1 + 1, s2);
            else                           score_point(s1, s2 + 1);
        end
        end_game();

        // Game 2: start and mode edges together, then a simultaneous 10->11.
        @(posedge clk65MHz);
        #1 btn_start = 1'b1;
        btn_mode = 1'b1;
        exp_multi = ~exp_multi;
        @(posedge clk65MHz);
        #1 btn_start = 1'b0;
        btn_mode = 1'b0;
        repeat (2) @(posedge clk65MHz);
        #1;
        check("both_edges_multi", screen_multi, exp_multi);
        check("both_edges_state", state_dbg, ST_WAIT_SERVE);
        serve_point();
        score_point(10, 10);
        score_point(11, 11);
        end_game();

        // Game 3: player 2 wins from a random position.
        if (!exp_multi) begin
            press(B_MODE, 2);
            exp_multi = 1'b1;
        end
        press(B_START, 3);
        serve_point();
        a = $urandom_range(0, 9);
        score_point(a, 10);
        score_point(a, 11);
        end_game();

        // Reset while a serve pulse is high.
        press(B_START, 2);
        check("pre_rst_multi", screen_multi, 1);
        sync_eof();
        press(B_SERVE, 1);
        guard = 0;
        while (!serve && guard < 200) begin
            @(negedge clk65MHz);
            guard++;
        end
        check("serve_seen_before_rst", serve, 1);
        rst = 1'b0;
        @(negedge clk65MHz);
        check("midserve_rst_serve", serve, 0);
        check("midserve_rst_state", state_dbg, ST_MENU);
        check("midserve_rst_idle", screen_idle, 1);
        check("midserve_rst_multi", screen_multi, 0);
        check("midserve_rst_winner", winner, 0);
        exp_multi = 1'b0;
        @(posedge clk65MHz);
        #1 rst = 1'b1;
        repeat (20) @(posedge clk65MHz);
        #1;
        check("post_rst_state", state_dbg, ST_MENU);
        check("post_rst_serve", serve, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/game_state_ctl.md
GAME_STATE_CTL -- requirements
Module: game_state_ctl

Interface
REQ-001 Parameter WIN_POINTS, default 4'd11, points needed to win a game (range 1..15).
REQ-002 Parameter PAUSE_FRAMES, default 8'd60, frames to freeze play after each scored point.
REQ-003 clk65MHz  input  1  the only clock; all state changes on its rising edge.
REQ-004 rst  input  1  synchronous, active-low reset, sampled on the rising edge of clk65MHz.
REQ-005 end_of_frame  input  1  one-cycle pulse per video frame.
REQ-006 btn_start  input  1  start/confirm button, already synchronised, level.
REQ-007 btn_mode  input  1  mode toggle button, already synchronised, level; 1 press = single/multi swap.
REQ-008 btn_serve  input  1  serve button, already synchronised, level.
REQ-009 points_player_1, points_player_2  input  4 each  current scores from ball_control.
REQ-010 screen_idle  output  1  high while the game is not being played (menu or game over).
REQ-011 screen_multi  output  1  selected mode: 1 = multiplayer, 0 = single player.
REQ-012 serve  output  1  serve request to ball_control, held high for exactly one frame.
REQ-013 winner  output  2  00 none, 01 player 1, 10 player 2.
REQ-014 state_dbg  output  3  encoded current state, for the on-screen debug overlay.

Function
REQ-015 States: MENU, WAIT_SERVE, PLAY, PAUSE, GAME_OVER.
REQ-016 All button inputs are acted on only at their rising edge (0->1, registered one cycle earlier); a held button SHALL produce one action only.
REQ-017 MENU: a btn_mode edge toggles screen_multi; a btn_start edge goes to WAIT_SERVE.
REQ-018 WAIT_SERVE: a btn_serve edge raises serve from the next end_of_frame until the following end_of_frame, then the block enters PLAY.
REQ-019 PLAY: a change in either points input, compared against a copy registered on each end_of_frame, goes to PAUSE and loads the frame counter with PAUSE_FRAMES.
REQ-020 If a player's score is at least WIN_POINTS when the change is seen, the block goes to GAME_OVER instead of PAUSE.
REQ-021 The winner is that player; if both players reach WIN_POINTS in the same frame, winner is 01.
REQ-022 PAUSE: the counter decrements once per end_of_frame; at zero the block goes to WAIT_SERVE.
REQ-023 GAME_OVER: winner holds its value; a btn_start edge goes to MENU and clears winner to 00.
REQ-024 screen_idle = 1 in MENU and GAME_OVER, 0 in all other states; it is a registered output.
REQ-025 btn_mode is ignored outside MENU; screen_multi SHALL NOT change during a game.
REQ-026 If btn_start and btn_mode edges occur in the same cycle in MENU, the toggle applies first and the start is taken with the new mode.
REQ-027 The frame counter is 8 bits and SHALL NOT wrap below zero.
REQ-028 If PAUSE_FRAMES = 0, PAUSE exits on the first end_of_frame.

Reset
REQ-029 While rst = 0: state MENU, screen_idle 1, screen_multi 0, serve 0, winner 00, counter 0, registered scores 0, button edge registers 0.
REQ-030 Reset asserted mid-game or mid-serve SHALL force these values on the next rising edge; a serve pulse in progress is dropped.

Configuration
REQ-031 Macro GAME_AUTO_SERVE_EN, when defined: WAIT_SERVE issues serve automatically on the first end_of_frame after entry, and btn_serve is ignored.
REQ-032 Without GAME_AUTO_SERVE_EN, serve is issued only on a btn_serve edge, as in REQ-018.

Structure
REQ-033 The state enum game_state_t and the winner codes are defined in game_pkg.
REQ-034 Defaults WIN_POINTS and PAUSE_FRAMES are defined in game_pkg.
REQ-035 The button rising-edge detector is one sub-module, btn_edge, instantiated three times.

Verification
REQ-036 Reset, then btn_mode press, then btn_start press -> screen_multi 1, screen_idle 0, state WAIT_SERVE.
REQ-037 In WAIT_SERVE, btn_serve held for 100 frames -> exactly one serve pulse lasting one frame, then PLAY.
REQ-038 In PLAY, points_player_2 goes 0->1 -> PAUSE; WAIT_SERVE after exactly 60 end_of_frame pulses; serve stays 0 throughout.
REQ-039 points_player_1 reaches 11 -> GAME_OVER, winner 01, screen_idle 1; btn_start press -> MENU, winner 00.
REQ-040 Both scores go 10->11 in the same frame -> winner 01.
REQ-041 rst pulled low in the frame a serve is high -> serve 0 and state MENU on the next edge; with GAME_AUTO_SERVE_EN defined, entering WAIT_SERVE -> serve on the first end_of_frame with no button press.
